// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - pixel strobe, pattern controls and registered video bus
interface vga_pattern_gen_if;
    logic       pix_en;
    logic [1:0] mode;
    logic [7:0] fill;
    logic       hsync;
    logic       vsync;
    logic       vidon;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       frame_start;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;

    modport master (
        input  pix_en, mode, fill,
        output hsync, vsync, vidon, hc, vc, frame_start, red, green, blue
    );

    modport slave (
        output pix_en, mode, fill,
        input  hsync, vsync, vidon, hc, vc, frame_start, red, green, blue
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised VGA timing and test pattern generator
// Optional border overlay: VGA_BORDER_EN.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int BAR_LOG2 = 6
) (
    input  logic              clk,
    input  logic              clr,
    vga_pattern_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    // Window bounds are 11 bits so a window ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || BAR_LOG2 + 2 > 9) begin : g_bad_params
            $error("vga_pattern_gen: timing totals or BAR_LOG2 out of range");
        end
    endgenerate

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [1:0]  mode_q;
    logic [10:0] hx;
    logic [10:0] vx;
    logic        h_wrap;
    logic        v_wrap;
    logic        active;
    logic        hs_win;
    logic        vs_win;
    logic [2:0]  idx;
    logic [7:0]  pix;

    always_comb begin
        hx     = {1'b0, hcnt};
        vx     = {1'b0, vcnt};
        h_wrap = (hcnt == H_LAST);
        v_wrap = (vcnt == V_LAST);
        active = (hx < H_ACT) && (vx < V_ACT);
        hs_win = (hx >= HS_ON) && (hx < HS_OFF);
        vs_win = (vx >= VS_ON) && (vx < VS_OFF);
    end

    always_comb begin
        idx = 3'd0;
        pix = 8'h00;
        case (mode_q)
            2'd0:    idx = hcnt[BAR_LOG2+2:BAR_LOG2];
            2'd1:    idx = vcnt[BAR_LOG2+2:BAR_LOG2];
            2'd2:    idx = {3{hcnt[BAR_LOG2] ^ vcnt[BAR_LOG2]}};
            default: idx = 3'd0;
        endcase
        if (mode_q == 2'd3) begin
            pix = vid.fill;
        end else begin
            pix = {{3{idx[2]}}, {3{idx[1]}}, {2{idx[0]}}};
        end
`ifdef VGA_BORDER_EN
        if (hcnt == 10'd0 || hx == H_ACT - 11'd1 || vcnt == 10'd0 || vx == V_ACT - 11'd1) begin
            pix = 8'hFF;
        end
`endif
        if (!active) begin
            pix = 8'h00;
        end
    end

    // mode_q only reloads when stepping into (0,0), so a frame is never torn.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hcnt   <= '0;
            vcnt   <= '0;
            mode_q <= '0;
        end else if (vid.pix_en) begin
            if (h_wrap) begin
                hcnt <= '0;
                if (v_wrap) begin
                    vcnt   <= '0;
                    mode_q <= vid.mode;
                end else begin
                    vcnt <= vcnt + 10'd1;
                end
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vid.hsync       <= ~SYNC_ACT;
            vid.vsync       <= ~SYNC_ACT;
            vid.vidon       <= 1'b0;
            vid.hc          <= '0;
            vid.vc          <= '0;
            vid.frame_start <= 1'b0;
            vid.red         <= '0;
            vid.green       <= '0;
            vid.blue        <= '0;
        end else if (vid.pix_en) begin
            vid.hsync       <= hs_win ? SYNC_ACT : ~SYNC_ACT;
            vid.vsync       <= vs_win ? SYNC_ACT : ~SYNC_ACT;
            vid.vidon       <= active;
            vid.hc          <= hcnt;
            vid.vc          <= vcnt;
            vid.frame_start <= (hcnt == 10'd0) && (vcnt == 10'd0);
            vid.red         <= pix[7:5];
            vid.green       <= pix[4:2];
            vid.blue        <= pix[1:0];
        end else begin
            vid.frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - random-stimulus bench against a raster-position reference model
module tb_vga_pattern_gen;
    localparam int HA = 48, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 24, VFP = 2, VS = 2, VBP = 3;
    localparam int BL = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam logic [31:0] SYNC_BITS = 32'hC000_0000;
    localparam logic [31:0] FS_BIT    = 32'h1000_0000;
    localparam logic [31:0] RST_VAL   = 32'hC000_0000;

    logic       clk = 1'b0;
    logic       clr;
    logic       pix_en;
    logic [1:0] mode;
    logic [7:0] fill;
    int         vectors = 0;
    int         miscompares = 0;

    vga_pattern_gen_if vlo ();
    vga_pattern_gen_if vhi ();

    assign vlo.pix_en = pix_en;
    assign vlo.mode   = mode;
    assign vlo.fill   = fill;
    assign vhi.pix_en = pix_en;
    assign vhi.mode   = mode;
    assign vhi.fill   = fill;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0), .BAR_LOG2(BL)
    ) dut_lo (.clk(clk), .clr(clr), .vid(vlo.master));

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1), .BAR_LOG2(BL)
    ) dut_hi (.clk(clk), .clr(clr), .vid(vhi.master));

    always #5 clk = ~clk;

    function automatic logic [31:0] pack_lo();
        return {vlo.hsync, vlo.vsync, vlo.vidon, vlo.frame_start, vlo.hc, vlo.vc,
                vlo.red, vlo.green, vlo.blue};
    endfunction

    function automatic logic [31:0] pack_hi();
        return {vhi.hsync, vhi.vsync, vhi.vidon, vhi.frame_start, vhi.hc, vhi.vc,
                vhi.red, vhi.green, vhi.blue};
    endfunction

    // Expected output word for raster position n (active-low sync), frame_start bit clear.
    function automatic logic [31:0] model(int n, int m, logic [7:0] f);
        int x = n % HT;
        int y = n / HT;
        int bar = 1 << BL;
        int i = 0;
        logic act = (x < HA) && (y < VA);
        logic hs  = !((x >= HA + HFP) && (x < HA + HFP + HS));
        logic vs  = !((y >= VA + VFP) && (y < VA + VFP + VS));
        logic [7:0] rgb;
        case (m)
            0: i = (x / bar) % 8;
            1: i = (y / bar) % 8;
            2: i = (((x / bar) + (y / bar)) % 2 == 1) ? 7 : 0;
            default: i = 0;
        endcase
        rgb = (m == 3) ? f : {{3{i[2]}}, {3{i[1]}}, {2{i[0]}}};
`ifdef VGA_BORDER_EN
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) rgb = 8'hFF;
`endif
        if (!act) rgb = 8'h00;
        return {hs, vs, act, 1'b0, 10'(x), 10'(y), rgb};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int n = 0;
        int mm = 0;
        int freeze = 0;
        logic [31:0] exp;

        clr = 1'b1;
        pix_en = 1'b0;
        mode = 2'd0;
        fill = 8'h00;
        #1;
        check("reset_lo", pack_lo(), RST_VAL);
        check("reset_hi", pack_hi(), RST_VAL ^ SYNC_BITS);
        repeat (3) @(negedge clk);
        clr = 1'b0;
        exp = RST_VAL;

        for (int c = 0; c < 14000; c++) begin
            if (c == 3001) freeze = 50;
            if (c % 1700 == 5) mode = 2'($urandom_range(0, 3));
            if (c % 2300 == 7) fill = 8'($urandom);

            if (c == 7777) begin
                #2 clr = 1'b1;
                #1;
                check("clr_async_lo", pack_lo(), RST_VAL);
                check("clr_async_hi", pack_hi(), RST_VAL ^ SYNC_BITS);
                n = 0;
                mm = 0;
                exp = RST_VAL;
                pix_en = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    check("clr_hold", pack_lo(), RST_VAL);
                end
                clr = 1'b0;
            end

            if (freeze > 0) begin
                pix_en = 1'b0;
                freeze--;
            end else begin
                pix_en = ($urandom_range(0, 9) < 6);
            end

            @(posedge clk);
            if (pix_en) begin
                exp = model(n, mm, fill) | ((n == 0) ? FS_BIT : 32'h0);
                if (n == FT - 1) mm = int'(mode);
                n = (n + 1) % FT;
            end else begin
                exp = exp & ~FS_BIT;
            end
            @(negedge clk);
            check("pix_lo", pack_lo(), exp);
            check("pix_hi", pack_hi(), exp ^ SYNC_BITS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
